// File: rtl/alu_share_sched.sv
// Round-robin scheduler time-sharing one 8-bit FSM ALU among NREQ requesters.
// One job in flight at a time; the result is returned tagged with the owner id.
`timescale 1ns/1ps
module alu_share_sched #(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 4,
    parameter int OPW     = 2,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_ain,
    input  logic [NREQ*8-1:0]   req_bin,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_data,
    output logic [7:0]          alu_ain,
    output logic [7:0]          alu_bin,
    output logic [OPW-1:0]      alu_op,
    output logic                alu_s,
    input  logic [31:0]         alu_out,
    output logic                busy
);

    // state  | meaning
    // IDLE   | arbitrating, req_ready offered to the round-robin winner
    // RUN    | alu_s high, counting ALU_LAT cycles
    // RESP   | result held on rsp_*, waiting for rsp_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] job_id;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] grant;
    logic           grant_hit;
    logic           accept;
    int             idx;

    always_comb begin
        grant_hit = 1'b0;
        grant     = '0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_hit && req_valid[idx]) begin
                grant_hit = 1'b1;
                grant     = IDW'(idx);
            end
        end
    end

    // Gated by rst so the handshake is dead while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst && state == S_IDLE && grant_hit)
            req_ready[grant] = 1'b1;
    end

    assign accept    = (state == S_IDLE) && grant_hit;
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            job_id   <= '0;
            cnt      <= '0;
            alu_ain  <= '0;
            alu_bin  <= '0;
            alu_op   <= '0;
            alu_s    <= 1'b0;
            rsp_id   <= '0;
            rsp_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_ain <= req_ain[int'(grant)*8 +: 8];
                        alu_bin <= req_bin[int'(grant)*8 +: 8];
                        alu_op  <= req_op[int'(grant)*OPW +: OPW];
                        job_id  <= grant;
                        rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        cnt     <= '0;
                        alu_s   <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt == CNT_LAST) begin
                        rsp_data <= alu_out;
                        rsp_id   <= job_id;
                        alu_s    <= 1'b0;
                        cnt      <= '0;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: begin
                    alu_s <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a behavioural ALU that only presents
// a valid result once alu_s has been high for ALU_LAT cycles.
`timescale 1ns/1ps
module tb_alu_share_sched;
    localparam int NREQ = 4, ALU_LAT = 4, OPW = 2, IDW = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*8-1:0]   req_ain = '0;
    logic [NREQ*8-1:0]   req_bin = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_data;
    logic [7:0]          alu_ain, alu_bin;
    logic [OPW-1:0]      alu_op;
    logic                alu_s;
    logic [31:0]         alu_out;
    logic                busy;

    int n_chk = 0;
    int n_err = 0;
    int s_cnt = 0;

    alu_share_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .OPW(OPW), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ain(req_ain), .req_bin(req_bin), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
        .alu_s(alu_s), .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU model: garbage until alu_s has been high for ALU_LAT cycles.
    always @(posedge clk) s_cnt <= alu_s ? s_cnt + 1 : 0;

    always_comb begin
        alu_out = 32'hDEAD_BEEF;
        if (alu_s && s_cnt >= ALU_LAT - 1) begin
            case (alu_op)
                2'd0: alu_out = 32'(alu_ain) + 32'(alu_bin);
                2'd1: alu_out = 32'(alu_ain) - 32'(alu_bin);
                2'd2: alu_out = 32'(alu_ain) * 32'(alu_bin);
                default: alu_out = 32'(alu_ain ^ alu_bin);
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [OPW-1:0] op);
        req_ain[i*8 +: 8]     = a;
        req_bin[i*8 +: 8]     = b;
        req_op[i*OPW +: OPW]  = op;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rspid"}, 32'(rsp_id), 32'd0);
        chk({tag, "_rspd"},  rsp_data, 32'd0);
        chk({tag, "_ain"},   32'(alu_ain), 32'd0);
        chk({tag, "_bin"},   32'(alu_bin), 32'd0);
        chk({tag, "_op"},    32'(alu_op), 32'd0);
        chk({tag, "_s"},     32'(alu_s), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    // Assumes IDLE with rsp_ready=1; next_valid is applied right after the accept edge.
    task automatic run_job(input int gid, input logic [31:0] exp, input logic [NREQ-1:0] next_valid);
        chk("grant", 32'(req_ready), 32'(1) << gid);
        step();
        req_valid = next_valid;
        chk("run_s", 32'(alu_s), 32'd1);
        chk("run_busy", 32'(busy), 32'd1);
        for (int k = 1; k < ALU_LAT; k++) begin
            step();
            chk("run_s_hold", 32'(alu_s), 32'd1);
            chk("run_no_rsp", 32'(rsp_valid), 32'd0);
        end
        step();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(gid));
        chk("rsp_data", rsp_data, exp);
        chk("rsp_s_low", 32'(alu_s), 32'd0);
        step();
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'd2, 2'd0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b1;
        #1;

        // Round robin with all requesters held valid: 0,1,2,3,0 (result = i+1+2)
        run_job(0, 32'd3, 4'b1111);
        run_job(1, 32'd4, 4'b1111);
        run_job(2, 32'd5, 4'b1111);
        run_job(3, 32'd6, 4'b1111);
        run_job(0, 32'd3, 4'b1111);

        // Reset mid-RUN of a req 2 job; rr_ptr is 1 so req 2 wins
        req_valid = 4'b0100;
        #1;
        chk("rst_grant2", 32'(req_ready), 32'b0100);
        step();
        chk("rst_run_s", 32'(alu_s), 32'd1);
        step();
        rst = 1'b0;
        #1;
        chk_all_zero("midrun_rst");
        req_valid = '0;
        step();
        rst = 1'b1;
        for (int k = 0; k < ALU_LAT + 2; k++) begin
            step();
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1111;
        #1;
        chk("rr_ptr_cleared", 32'(req_ready), 32'b0001);

        // Single job from req 1 (10*3) with back-pressure and operand change in RUN
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        set_req(1, 8'd10, 8'd3, 2'b10);
        set_req(0, 8'd7, 8'd5, 2'b00);
        #1;
        chk("single_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        req_ain[15:8] = 8'd8;
        for (int k = 0; k < ALU_LAT; k++) begin
            chk("single_s", 32'(alu_s), 32'd1);
            chk("single_ain_stable", 32'(alu_ain), 32'd10);
            chk("single_bin", 32'(alu_bin), 32'd3);
            chk("single_op", 32'(alu_op), 32'b10);
            step();
        end
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_data", rsp_data, 32'd30);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_s", 32'(alu_s), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_released", 32'(rsp_valid), 32'd0);
        // req 0 job: 7+5
        run_job(0, 32'd12, 4'b1000);

        // Pointer wrap: grant 3 (200-100), then 0 and 2 both valid -> 0 first
        set_req(3, 8'd200, 8'd100, 2'b01);
        set_req(2, 8'hF0, 8'h0F, 2'b11);
        run_job(3, 32'd100, 4'b0101);
        run_job(0, 32'd12, 4'b0101);
        run_job(2, 32'hFF, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "timeout");
    end
endmodule
